// File: rtl/uart_rx_pkg.sv
// Shared UART types: receiver/transmitter FSM state encoding and default bit timing.
package types;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
module sync_ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-entry output register with
// valid/ready handshake, frame-error and overrun pulses.
module uart_rx
    import types::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] dout_n;
    logic                 dv_n, fe_n, ov_n;
    logic [1:0]           primed;
    logic                 armed;

    sync_ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // The synchronizer's reset value is not a real line sample, so arming waits
    // until both flops hold post-reset data and the line is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= '0;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            data_out   <= dout_n;
            data_valid <= dv_n;
            frame_err  <= fe_n;
            overrun    <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        dout_n  = data_out;
        dv_n    = data_valid && !data_ready;
        fe_n    = 1'b0;
        ov_n    = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (armed && !rx_s)
                    state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    if (idx == IDX_LAST)
                        state_n = STOP;
                    else
                        idx_n = idx + IW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx_s) begin
                        fe_n = 1'b1;
                    end else if (!data_valid || data_ready) begin
                        dout_n = shift;
                        dv_n   = 1'b1;
                    end else begin
                        ov_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed frames plus
// randomized frames, compared against a frame-level delivery model.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: outcome of each frame decided from its stop bit, the
    // pending-byte flag and the consumer's ready level during that frame.
    logic [7:0] exp_bytes[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    bit         model_valid = 0;

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit ready);
        if (ready) model_valid = 0;
        if (!stop_ok) begin
            exp_fe++;
        end else if (model_valid && !ready) begin
            exp_ov++;
        end else begin
            exp_bytes.push_back(b);
            model_valid = !ready;
        end
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    logic [7:0] obs_bytes[$];
    int         obs_fe = 0;
    int         obs_ov = 0;
    int         dv_cycles = 0;
    int         cyc = 0;
    int         load_cycle = 0;
    int         start_cycle = 0;
    logic       prev_dv = 0, prev_fe = 0, prev_ov = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (data_valid && !(prev_dv && !data_ready)) begin
            obs_bytes.push_back(data_out);
            load_cycle = cyc;
        end
        if (data_valid) dv_cycles++;
        if (frame_err) begin
            obs_fe++;
            check_eq("frame_err_width", {31'd0, prev_fe}, 32'd0);
        end
        if (overrun) begin
            obs_ov++;
            check_eq("overrun_width", {31'd0, prev_ov}, 32'd0);
        end
        if (frame_err || overrun)
            check_eq("err_exclusive", {31'd0, frame_err && overrun}, 32'd0);
        prev_dv = data_valid;
        prev_fe = frame_err;
        prev_ov = overrun;
    end

    task automatic hold_bit(input logic v, input int unsigned n);
        @(negedge clk);
        rx = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        hold_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        model_frame(b, stop_ok, data_ready);
        @(negedge clk);
        rx = 1'b0;
        start_cycle = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) hold_bit(b[i], CPB);
        hold_bit(stop_ok ? 1'b1 : 1'b0, CPB);
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic compare_and_clear(input string name);
        repeat (40) @(negedge clk);
        check_eq({name, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
            check_eq({name, "_byte"}, {24'd0, obs_bytes[i]}, {24'd0, exp_bytes[i]});
        check_eq({name, "_frame_err"}, obs_fe, exp_fe);
        check_eq({name, "_overrun"}, obs_ov, exp_ov);
        obs_bytes.delete();
        exp_bytes.delete();
        obs_fe = 0; exp_fe = 0;
        obs_ov = 0; exp_ov = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx = 1'b1;
        data_ready = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("reset_data_out", {24'd0, data_out}, 32'd0);
        check_eq("reset_valid", {31'd0, data_valid}, 32'd0);
        check_eq("reset_errs", {30'd0, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // 0xA5, ready high: one byte, valid one cycle, latency from start edge
        dv_cycles = 0;
        send_frame(8'hA5, 1);
        idle(20);
        check_eq("a5_latency_ok", {31'd0, (load_cycle - start_cycle >= 154) &&
                                          (load_cycle - start_cycle <= 156)}, 32'd1);
        check_eq("a5_valid_cycles", dv_cycles, 32'd1);
        compare_and_clear("a5");

        // glitch on the line, then a real frame
        hold_bit(1'b0, 4);
        idle(32);
        send_frame(8'h3C, 1);
        compare_and_clear("glitch");

        // bad stop bit, line returns idle, then a good frame
        send_frame(8'h3C, 0);
        idle(40);
        send_frame(8'h0F, 1);
        compare_and_clear("frame_err");

        // back-to-back with consumer stalled: second byte overruns
        data_ready = 1'b0;
        send_frame(8'h11, 1);
        send_frame(8'h22, 1);
        compare_and_clear("overrun");
        check_eq("stall_data_out", {24'd0, data_out}, 32'h11);
        check_eq("stall_valid", {31'd0, data_valid}, 32'd1);
        @(negedge clk);
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("accept_valid_clear", {31'd0, data_valid}, 32'd0);
        check_eq("accept_data_hold", {24'd0, data_out}, 32'h11);
        model_valid = 0;

        // reset in the middle of data bit 3 of 0xFF
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 3; i++) hold_bit(1'b1, CPB);
        hold_bit(1'b1, CPB / 2);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_data_out", {24'd0, data_out}, 32'd0);
        check_eq("midreset_valid", {31'd0, data_valid}, 32'd0);
        check_eq("midreset_errs", {30'd0, frame_err, overrun}, 32'd0);
        // line held low across reset release must not start a frame
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_valid = 0;
        hold_bit(1'b0, 3 * CPB);
        idle(32);
        send_frame(8'h5A, 1);
        compare_and_clear("after_reset");

        // extreme data patterns back to back
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        compare_and_clear("zero_ff");

        // randomized frames: byte, consumer readiness, stop-bit errors, gaps
        for (int n = 0; n < 14; n++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            data_ready = 1'($urandom_range(0, 1));
            send_frame(b, ok);
            if (!ok) idle(40);
            else if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 20));
        end
        compare_and_clear("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); SHALL be >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 data_out  output  DATA_BITS  last received byte.
REQ-007 data_valid  output  1  data_out holds an unconsumed byte.
REQ-008 data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, with one bit-period counter and one data-bit index.
REQ-013 IDLE: rx_s == 0 -> START, counter cleared.
REQ-014 START: at counter == CLKS_PER_BIT/2 - 1, rx_s == 0 -> DATA, counter cleared; rx_s == 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: at counter == CLKS_PER_BIT - 1, sample rx_s into shift register LSB first, clear counter, increment index; after bit DATA_BITS-1 -> STOP.
REQ-016 STOP: at counter == CLKS_PER_BIT - 1, sample rx_s; state -> IDLE in the same cycle regardless of value.
REQ-017 Stop sample 1: byte is complete; stop sample 0: frame_err pulses high for exactly one cycle, byte discarded, data_valid unchanged.
REQ-018 Completed byte with data_valid == 0, or with data_valid == 1 and data_ready == 1 in the same cycle: data_out loads the byte and data_valid is 1 on the next cycle.
REQ-019 Completed byte with data_valid == 1 and data_ready == 0: overrun pulses one cycle; data_out and data_valid are unchanged (old byte kept).
REQ-020 data_valid && data_ready with no completion in that cycle: data_valid clears next cycle; data_out holds its value.
REQ-021 data_valid SHALL rise 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles (+/-1 for edge phase) after the rx falling edge of the start bit.
REQ-022 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss, since the FSM reaches IDLE at mid-stop-bit.
REQ-023 frame_err and overrun SHALL never assert in the same cycle as each other.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, counters 0, shift register 0, data_out 0, data_valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the receiver SHALL wait for a fresh falling edge and SHALL NOT treat a line already held low as a start bit until rx_s has been seen high.

Structure
REQ-026 The FSM state enum uart_rx_state_t and the default CLKS_PER_BIT constant SHALL live in package types, shared with uart_tx.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_ff (parameter reset value), reusable by other interdevice_controller inputs.
REQ-028 Expected RTL size: 150-250 lines, single clock domain after sync_ff.

Verification (CLKS_PER_BIT = 16, bench drives rx at 16 clk per bit)
REQ-029 Frame 0xA5 with valid stop, data_ready = 1 -> data_out = 0xA5, data_valid high one cycle, frame_err = 0, overrun = 0.
REQ-030 rx low for 4 cycles then high -> no data_valid, no frame_err; subsequent frame 0x3C is received correctly.
REQ-031 Frame 0x3C with stop bit 0 -> frame_err single-cycle pulse, data_valid stays 0; next frame 0x0F is received correctly.
REQ-032 Back-to-back 0x11, 0x22 with data_ready = 0 -> data_out = 0x11, overrun pulses once at the 0x22 stop sample; data_ready = 1 -> data_valid clears.
REQ-033 Reset pulsed during data bit 3 of 0xFF -> all outputs 0 immediately; following frame 0x5A -> data_out = 0x5A, no errors.
REQ-034 Frames 0x00 and 0xFF back-to-back with data_ready = 1 -> both bytes delivered in order, no errors.
